// File: rtl/char_pkg.sv
// char_pkg
// Shared definitions for the per-player character action FSM:
//   - state_t : 4-bit state encodings shared by the FSM, its interface and benches
//   - STATE_W : width of the state field
//   - DEF_*   : default frame data (all in frame ticks)
//   - frames_ok() : elaboration-time range check for frame-data parameters
package char_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = 4'd0,
    ST_LEFT         = 4'd1,
    ST_RIGHT        = 4'd2,
    ST_ATK_START    = 4'd3,
    ST_ATK_ACTIVE   = 4'd4,
    ST_ATK_RECOVERY = 4'd5,
    ST_DIR_START    = 4'd6,
    ST_DIR_ACTIVE   = 4'd7,
    ST_DIR_RECOVERY = 4'd8,
    ST_HITSTUN      = 4'd9,
    ST_BLOCKSTUN    = 4'd10
  } state_t;

  localparam int DEF_CNT_W               = 5;
  localparam int DEF_NEU_STARTUP_FRAMES  = 5;
  localparam int DEF_NEU_ACTIVE_FRAMES   = 2;
  localparam int DEF_NEU_RECOVERY_FRAMES = 16;
  localparam int DEF_DIR_STARTUP_FRAMES  = 4;
  localparam int DEF_DIR_ACTIVE_FRAMES   = 3;
  localparam int DEF_DIR_RECOVERY_FRAMES = 15;
  localparam int DEF_HITSTUN_FRAMES      = 12;
  localparam int DEF_BLOCKSTUN_FRAMES    = 8;
  localparam int DEF_BUFFER_WIN          = 4;

  // A duration must be at least one tick and must fit in the frame counter.
  function automatic bit frames_ok(input int frames, input int cnt_w);
    return (frames >= 1) && (frames < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/char_action_fsm_if.sv
// char_action_fsm_if
// Groups the per-player control inputs and status outputs of char_action_fsm.
//   master : input-conditioning / game-logic side (drives keys, tick, hit)
//   slave  : the character FSM (drives state and status flags)
// Signals:
//   frame_tick   one-clock pulse per game frame
//   key_left/key_right/key_attack  conditioned active-high keys
//   facing_right 1 = back key is key_left
//   hit          one-clock pulse from the collision unit
//   state        current state encoding (char_pkg::state_t)
//   frames_left  remaining frames of a timed state, 0 otherwise
//   hitbox_active, attack_dir, blocking  decoded status flags
interface char_action_fsm_if
  import char_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic               frame_tick;
  logic               key_left;
  logic               key_right;
  logic               key_attack;
  logic               facing_right;
  logic               hit;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   frames_left;
  logic               hitbox_active;
  logic               attack_dir;
  logic               blocking;

  modport master (
    output frame_tick, key_left, key_right, key_attack, facing_right, hit,
    input  state, frames_left, hitbox_active, attack_dir, blocking
  );

  modport slave (
    input  frame_tick, key_left, key_right, key_attack, facing_right, hit,
    output state, frames_left, hitbox_active, attack_dir, blocking
  );

endinterface

// File: rtl/char_phase_timer.sv
// char_phase_timer
// Frame counter for the timed FSM phases. Advances only on tick.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   tick        frame tick; nothing changes without it
//   load        on a tick, replace the count with load_val
//   load_val    next phase duration (0 for untimed states)
//   count       current remaining frames
//   done        tick while count==1, i.e. the current phase ends this tick
module char_phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = tick && (count == CNT_W'(1));

  // Saturates at zero so an unloaded counter in an untimed state stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      if (load) begin
        count <= load_val;
      end else if (count != '0) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/char_action_fsm.sv
// char_action_fsm
// Per-player character action FSM: walking, neutral and directional attacks
// (startup/active/recovery), hitstun and blockstun, paced by frame_tick.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    char_action_fsm_if.slave (keys, tick, hit in; state/status out)
// Optional feature macro: CHAR_INPUT_BUFFER_EN
//   When defined, an attack press late in a recovery phase is buffered and
//   the recovery exits straight into a new attack instead of IDLE.
module char_action_fsm
  import char_pkg::*;
#(
  parameter int CNT_W               = DEF_CNT_W,
  parameter int NEU_STARTUP_FRAMES  = DEF_NEU_STARTUP_FRAMES,
  parameter int NEU_ACTIVE_FRAMES   = DEF_NEU_ACTIVE_FRAMES,
  parameter int NEU_RECOVERY_FRAMES = DEF_NEU_RECOVERY_FRAMES,
  parameter int DIR_STARTUP_FRAMES  = DEF_DIR_STARTUP_FRAMES,
  parameter int DIR_ACTIVE_FRAMES   = DEF_DIR_ACTIVE_FRAMES,
  parameter int DIR_RECOVERY_FRAMES = DEF_DIR_RECOVERY_FRAMES,
  parameter int HITSTUN_FRAMES      = DEF_HITSTUN_FRAMES,
  parameter int BLOCKSTUN_FRAMES    = DEF_BLOCKSTUN_FRAMES,
  parameter int BUFFER_WIN          = DEF_BUFFER_WIN
) (
  input  logic                clk,
  input  logic                rst_n,
  char_action_fsm_if.slave    bus
);

  localparam bit FRAME_DATA_OK =
    frames_ok(NEU_STARTUP_FRAMES, CNT_W) && frames_ok(NEU_ACTIVE_FRAMES, CNT_W) &&
    frames_ok(NEU_RECOVERY_FRAMES, CNT_W) && frames_ok(DIR_STARTUP_FRAMES, CNT_W) &&
    frames_ok(DIR_ACTIVE_FRAMES, CNT_W) && frames_ok(DIR_RECOVERY_FRAMES, CNT_W) &&
    frames_ok(HITSTUN_FRAMES, CNT_W) && frames_ok(BLOCKSTUN_FRAMES, CNT_W) &&
    (BUFFER_WIN >= 0) && (BUFFER_WIN < (1 << CNT_W));

  if (!FRAME_DATA_OK) begin : g_bad_frame_data
    $error("char_action_fsm: frame data must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] NEU_S_C = CNT_W'(NEU_STARTUP_FRAMES);
  localparam logic [CNT_W-1:0] NEU_A_C = CNT_W'(NEU_ACTIVE_FRAMES);
  localparam logic [CNT_W-1:0] NEU_R_C = CNT_W'(NEU_RECOVERY_FRAMES);
  localparam logic [CNT_W-1:0] DIR_S_C = CNT_W'(DIR_STARTUP_FRAMES);
  localparam logic [CNT_W-1:0] DIR_A_C = CNT_W'(DIR_ACTIVE_FRAMES);
  localparam logic [CNT_W-1:0] DIR_R_C = CNT_W'(DIR_RECOVERY_FRAMES);
  localparam logic [CNT_W-1:0] HIT_C   = CNT_W'(HITSTUN_FRAMES);
  localparam logic [CNT_W-1:0] BLK_C   = CNT_W'(BLOCKSTUN_FRAMES);

  state_t           state;
  state_t           next_state;
  state_t           rec_exit;
  logic [CNT_W-1:0] rec_load;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;
  logic             load;
  logic             done;
  logic             hit_pending;
  logic             atk_prev;
  logic             hit_now;
  logic             press;
  logic             back_key;
  logic             dir_held;
  logic             hitbox_q;
  logic             dir_q;
  logic             blk_q;

  // A hit pulse on the tick cycle itself counts the same as a latched one.
  assign hit_now  = bus.hit | hit_pending;
  assign press    = bus.key_attack & ~atk_prev;
  assign back_key = bus.facing_right ? bus.key_left : bus.key_right;
  assign dir_held = bus.key_left | bus.key_right;

  char_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (bus.frame_tick),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .done     (done)
  );

`ifdef CHAR_INPUT_BUFFER_EN
  logic buf_atk;
  logic in_win;
  logic buf_now;

  // A press on the expiry tick itself also counts, it is inside the window.
  assign in_win   = (int'(count) <= BUFFER_WIN);
  assign buf_now  = buf_atk | (press & in_win);
  assign rec_exit = !buf_now ? ST_IDLE : (dir_held ? ST_DIR_START : ST_ATK_START);
  assign rec_load = !buf_now ? '0 : (dir_held ? DIR_S_C : NEU_S_C);

  // Buffered press lives only within one recovery; hits and exits drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_atk <= 1'b0;
    end else if (bus.frame_tick) begin
      if (hit_now || done) begin
        buf_atk <= 1'b0;
      end else if (state inside {ST_ATK_RECOVERY, ST_DIR_RECOVERY}) begin
        if (press && in_win) begin
          buf_atk <= 1'b1;
        end
      end else begin
        buf_atk <= 1'b0;
      end
    end
  end
`else
  assign rec_exit = ST_IDLE;
  assign rec_load = '0;
`endif

  // Next-state decision for a tick: pending hit first, then phase expiry,
  // then keys. Timed states that are not expiring leave load low so the
  // timer simply counts down.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_val   = '0;
    if (bus.frame_tick) begin
      if (hit_now) begin
        load = 1'b1;
        if (back_key && (state inside {ST_IDLE, ST_LEFT, ST_RIGHT, ST_BLOCKSTUN})) begin
          next_state = ST_BLOCKSTUN;
          load_val   = BLK_C;
        end else begin
          next_state = ST_HITSTUN;
          load_val   = HIT_C;
        end
      end else begin
        case (state)
          ST_IDLE, ST_LEFT, ST_RIGHT: begin
            load = 1'b1;
            if (press && dir_held) begin
              next_state = ST_DIR_START;
              load_val   = DIR_S_C;
            end else if (press) begin
              next_state = ST_ATK_START;
              load_val   = NEU_S_C;
            end else if (bus.key_left) begin
              next_state = ST_LEFT;
            end else if (bus.key_right) begin
              next_state = ST_RIGHT;
            end else begin
              next_state = ST_IDLE;
            end
          end
          ST_ATK_START: if (done) begin
            next_state = ST_ATK_ACTIVE;
            load       = 1'b1;
            load_val   = NEU_A_C;
          end
          ST_ATK_ACTIVE: if (done) begin
            next_state = ST_ATK_RECOVERY;
            load       = 1'b1;
            load_val   = NEU_R_C;
          end
          ST_DIR_START: if (done) begin
            next_state = ST_DIR_ACTIVE;
            load       = 1'b1;
            load_val   = DIR_A_C;
          end
          ST_DIR_ACTIVE: if (done) begin
            next_state = ST_DIR_RECOVERY;
            load       = 1'b1;
            load_val   = DIR_R_C;
          end
          ST_ATK_RECOVERY, ST_DIR_RECOVERY: if (done) begin
            next_state = rec_exit;
            load       = 1'b1;
            load_val   = rec_load;
          end
          ST_HITSTUN, ST_BLOCKSTUN: if (done) begin
            next_state = ST_IDLE;
            load       = 1'b1;
          end
          default: begin
            next_state = ST_IDLE;
            load       = 1'b1;
          end
        endcase
      end
    end
  end

  // State, hit latch, attack edge history and registered status flags.
  // Flags are decoded from next_state so they line up with STATE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hit_pending <= 1'b0;
      atk_prev    <= 1'b1;
      hitbox_q    <= 1'b0;
      dir_q       <= 1'b0;
      blk_q       <= 1'b0;
    end else begin
      state    <= next_state;
      hitbox_q <= next_state inside {ST_ATK_ACTIVE, ST_DIR_ACTIVE};
      dir_q    <= next_state inside {ST_DIR_START, ST_DIR_ACTIVE, ST_DIR_RECOVERY};
      blk_q    <= (next_state == ST_BLOCKSTUN);
      if (bus.frame_tick) begin
        hit_pending <= 1'b0;
        atk_prev    <= bus.key_attack;
      end else if (bus.hit) begin
        hit_pending <= 1'b1;
      end
    end
  end

  assign bus.state         = state;
  assign bus.frames_left   = count;
  assign bus.hitbox_active = hitbox_q;
  assign bus.attack_dir    = dir_q;
  assign bus.blocking      = blk_q;

endmodule

// File: tb/tb_char_action_fsm.sv
// tb_char_action_fsm
// Directed scoreboard bench for char_action_fsm. Each tick issued by the
// stimulus pushes the expected state/frames/flags; a monitor pops and
// compares on the clock following every tick.
// Honours CHAR_INPUT_BUFFER_EN for the recovery-buffer vector.
module tb_char_action_fsm;
  import char_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] fl;
    logic       hb;
    logic       ad;
    logic       bl;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_seen = 1'b0;
  int   total = 0;
  int   bad = 0;
  obs_t exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  char_action_fsm_if #(.CNT_W(5)) bus();

  char_action_fsm #(.CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Status flags follow directly from the state definitions.
  function automatic obs_t make_obs(input int st, input int fl);
    obs_t o;
    o.st = 4'(st);
    o.fl = 5'(fl);
    o.hb = (st == 4) || (st == 7);
    o.ad = (st == 6) || (st == 7) || (st == 8);
    o.bl = (st == 10);
    return o;
  endfunction

  function automatic obs_t sample();
    return {bus.state, bus.frames_left, bus.hitbox_active, bus.attack_dir, bus.blocking};
  endfunction

  task automatic checkOutput(input obs_t got, input obs_t want, input string name);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got st=%0d fl=%0d hb=%0b ad=%0b bl=%0b, want st=%0d fl=%0d hb=%0b ad=%0b bl=%0b",
               name, got.st, got.fl, got.hb, got.ad, got.bl,
               want.st, want.fl, want.hb, want.ad, want.bl);
    end
  endtask

  always @(posedge clk) tick_seen <= bus.frame_tick;

  // Monitor: outputs are valid in the cycle after each tick.
  always @(negedge clk) begin
    if (tick_seen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_tick: got st=%0d, want no output", bus.state);
      end else begin
        checkOutput(sample(), exp_q.pop_front(), name_q.pop_front());
      end
    end
  end

  // One frame tick (optionally with a coincident hit), then three idle clocks.
  task automatic applyStimulus(input int st, input int fl, input string name,
                               input bit with_hit = 1'b0);
    exp_q.push_back(make_obs(st, fl));
    name_q.push_back(name);
    @(posedge clk); #1;
    bus.frame_tick = 1'b1;
    bus.hit = with_hit;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    bus.hit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_hit();
    @(posedge clk); #1;
    bus.hit = 1'b1;
    @(posedge clk); #1;
    bus.hit = 1'b0;
  endtask

  task automatic neutral_to_recovery(input string tag, input int stop_fl);
    bus.key_attack = 1'b1;
    applyStimulus(3, 5, {tag, "_press"});
    bus.key_attack = 1'b0;
    for (int i = 4; i >= 1; i--) applyStimulus(3, i, {tag, "_start"});
    for (int i = 2; i >= 1; i--) applyStimulus(4, i, {tag, "_active"});
    for (int i = 16; i >= stop_fl; i--) applyStimulus(5, i, {tag, "_recovery"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, want finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.frame_tick   = 1'b0;
    bus.key_left     = 1'b0;
    bus.key_right    = 1'b0;
    bus.key_attack   = 1'b1;
    bus.facing_right = 1'b0;
    bus.hit          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput(sample(), make_obs(0, 0), "reset_state");
    rst_n = 1'b1;

    // Attack held through reset must not fire.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, "held_through_reset");
    bus.key_attack = 1'b0;
    applyStimulus(0, 0, "attack_release");

    // Full neutral attack, then back to idle.
    neutral_to_recovery("neu", 1);
    applyStimulus(0, 0, "neu_to_idle");

    // Directional attack with right held; right stays held through expiry.
    bus.key_right  = 1'b1;
    bus.key_attack = 1'b1;
    applyStimulus(6, 4, "dir_press");
    bus.key_attack = 1'b0;
    for (int i = 3; i >= 1; i--) applyStimulus(6, i, "dir_start");
    for (int i = 3; i >= 1; i--) applyStimulus(7, i, "dir_active");
    for (int i = 15; i >= 1; i--) applyStimulus(8, i, "dir_recovery");
    applyStimulus(0, 0, "dir_to_idle");
    applyStimulus(2, 0, "right_walk");
    bus.key_right = 1'b0;
    applyStimulus(0, 0, "right_release");

    // Hit between ticks during neutral active, then re-hit with the tick.
    bus.key_attack = 1'b1;
    applyStimulus(3, 5, "hit_setup_press");
    bus.key_attack = 1'b0;
    for (int i = 4; i >= 1; i--) applyStimulus(3, i, "hit_setup_start");
    applyStimulus(4, 2, "hit_setup_active");
    pulse_hit();
    applyStimulus(9, 12, "hit_from_active");
    for (int i = 11; i >= 3; i--) applyStimulus(9, i, "hitstun");
    applyStimulus(9, 12, "rehit_reload", 1'b1);
    for (int i = 11; i >= 1; i--) applyStimulus(9, i, "hitstun_after_rehit");
    applyStimulus(0, 0, "hitstun_to_idle");

    // Block: facing right with the back key (left) held.
    bus.facing_right = 1'b1;
    bus.key_left     = 1'b1;
    applyStimulus(1, 0, "left_walk");
    pulse_hit();
    applyStimulus(10, 8, "block_enter");
    for (int i = 7; i >= 1; i--) applyStimulus(10, i, "blockstun");
    applyStimulus(0, 0, "block_expiry");
    applyStimulus(1, 0, "left_after_block");
    bus.key_left = 1'b0;

    // Forward key held is no block.
    bus.key_right = 1'b1;
    applyStimulus(2, 0, "right_walk_fwd");
    pulse_hit();
    applyStimulus(9, 12, "fwd_hit");
    bus.key_right = 1'b0;
    for (int i = 11; i >= 1; i--) applyStimulus(9, i, "fwd_hitstun");
    applyStimulus(0, 0, "fwd_to_idle");

    // Both directions held resolves to LEFT.
    bus.key_left  = 1'b1;
    bus.key_right = 1'b1;
    applyStimulus(1, 0, "both_dirs");
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;
    applyStimulus(0, 0, "idle_again");

    // Press at FRAMES_LEFT=3 of neutral recovery.
    neutral_to_recovery("buf", 3);
    bus.key_attack = 1'b1;
    applyStimulus(5, 2, "buf_press");
    applyStimulus(5, 1, "buf_last");
`ifdef CHAR_INPUT_BUFFER_EN
    applyStimulus(3, 5, "buf_exit");
`else
    applyStimulus(0, 0, "buf_exit");
`endif
    bus.key_attack = 1'b0;

    repeat (4) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
